// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cache_pkg
// Purpose  : Shared geometry, fill FSM state type and block-alignment helper.
// Revision : 1.0
// ============================================================================
package cache_pkg;

  localparam int ADDR_WIDTH  = 16;
  localparam int BLOCK_WORDS = 8;
  localparam int OFFSET_BITS = 4;
  localparam int WORD_IDX_W  = $clog2(BLOCK_WORDS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // Clears the byte-offset bits; callers narrow the result to their own width.
  function automatic logic [31:0] block_base(input logic [31:0] addr,
                                             input int          offset_bits);
    return addr & ~((32'd1 << offset_bits) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fill_counter.sv
`default_nettype none
// ============================================================================
// Module   : fill_counter
// Purpose  : Clear/enable up-counter with a terminal-count compare flag.
// Revision : 1.0
// ============================================================================
module fill_counter #(
  parameter int WIDTH    = 4,
  parameter int TC_VALUE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign tc    = (r_count == WIDTH'(TC_VALUE));

endmodule
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_fsm
// Purpose  : Cache-miss block fill: issues BLOCK_WORDS reads, streams the
//            returned words into the data array and pulses the tag write.
// Revision : 1.0
// ============================================================================
module cache_fill_fsm #(
  parameter int ADDR_WIDTH  = cache_pkg::ADDR_WIDTH,
  parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
  parameter int OFFSET_BITS = cache_pkg::OFFSET_BITS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           miss_detected,
  input  logic [ADDR_WIDTH-1:0]          miss_address,
  input  logic [15:0]                    memory_data,
  input  logic                           memory_data_valid,
  output logic                           fsm_busy,
  output logic                           mem_enable,
  output logic                           mem_wr,
  output logic [ADDR_WIDTH-1:0]          memory_address,
  output logic                           write_data_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
  output logic [15:0]                    fill_data,
  output logic                           write_tag_array
);

  import cache_pkg::*;

  localparam int IDX_W = $clog2(BLOCK_WORDS);

  fill_state_t           r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [IDX_W:0]        w_req_cnt;
  logic [IDX_W-1:0]      w_rsp_cnt;
  logic                  w_req_done;
  logic                  w_last_rsp;
  logic                  w_start;
  logic                  w_in_fill;

  assign w_in_fill = (r_state == FILL);
  assign w_start   = (r_state == IDLE) && miss_detected;

  // Request and response counters run independently so any memory latency works.
  fill_counter #(
    .WIDTH    (IDX_W + 1),
    .TC_VALUE (BLOCK_WORDS)
  ) u_req_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_start),
    .en    (mem_enable),
    .count (w_req_cnt),
    .tc    (w_req_done)
  );

  fill_counter #(
    .WIDTH    (IDX_W),
    .TC_VALUE (BLOCK_WORDS - 1)
  ) u_rsp_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_start),
    .en    (write_data_array),
    .count (w_rsp_cnt),
    .tc    (w_last_rsp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_base  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (miss_detected) begin
            r_base  <= ADDR_WIDTH'(block_base(32'(miss_address), OFFSET_BITS));
            r_state <= FILL;
          end
        end
        FILL: begin
          if (write_tag_array) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fsm_busy         = w_in_fill;
  assign mem_enable       = w_in_fill && !w_req_done;
  assign mem_wr           = 1'b0;
  assign memory_address   = mem_enable ? (r_base + ADDR_WIDTH'({w_req_cnt, 1'b0})) : r_base;
  assign write_data_array = w_in_fill && memory_data_valid;
  assign fill_word_idx    = w_rsp_cnt;
  assign fill_data        = memory_data;
  assign write_tag_array  = write_data_array && w_last_rsp;

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_fill_fsm
// Purpose  : Scoreboard bench for cache_fill_fsm with a latency/burst memory model.
// Revision : 1.0
// ============================================================================
module tb_cache_fill_fsm;

  typedef struct {int cyc; logic [15:0] addr;} req_t;
  typedef struct {int cyc; logic [2:0] idx; logic [15:0] data; logic tag;} wr_t;
  typedef struct {int due; logic [15:0] addr;} pend_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy, mem_enable, mem_wr, write_data_array, write_tag_array;
  logic [15:0] memory_address, fill_data;
  logic [2:0]  fill_word_idx;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int m     = 0;

  bit          zl = 1'b1;
  int          lat = 0;
  int          period = 0;
  int          gate_base = 0;
  logic        mdl_valid = 1'b0;
  logic [15:0] mdl_data = '0;

  req_t  exp_req[$];
  wr_t   exp_wr[$];
  pend_t pend[$];

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_enable        (mem_enable),
    .mem_wr            (mem_wr),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_word_idx     (fill_word_idx),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic bit gate_ok(input int c);
    if (period == 0) return 1'b1;
    return (c >= gate_base) && (((c - gate_base) % period) == 0);
  endfunction

  // Zero-latency memory ties valid to the request; otherwise the queued model answers.
  assign memory_data_valid = zl ? mem_enable : mdl_valid;
  assign memory_data       = zl ? mem_word(memory_address) : mdl_data;

  always @(posedge clk) begin
    #1;
    mdl_valid = 1'b0;
    if (!zl && pend.size() > 0 && pend[0].due <= cyc && gate_ok(cyc)) begin
      mdl_valid = 1'b1;
      mdl_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
  end

  // Monitor: pops the scoreboard whenever the DUT requests or writes.
  always @(negedge clk) begin
    req_t e;
    wr_t  w;
    if (mem_enable) begin
      n_vec++;
      if (exp_req.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_req: addr=%h cyc=%0d, none expected", memory_address, cyc);
      end else begin
        e = exp_req.pop_front();
        if (memory_address !== e.addr || mem_wr !== 1'b0 || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL req: got addr=%h wr=%b cyc=%0d, want addr=%h wr=0 cyc=%0d",
                   memory_address, mem_wr, cyc, e.addr, e.cyc);
        end
      end
      if (!zl) pend.push_back('{cyc + lat, memory_address});
    end
    if (write_data_array) begin
      n_vec++;
      if (exp_wr.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: idx=%0d cyc=%0d, none expected", fill_word_idx, cyc);
      end else begin
        w = exp_wr.pop_front();
        if (fill_word_idx !== w.idx || fill_data !== w.data || write_tag_array !== w.tag ||
            cyc != w.cyc) begin
          n_bad++;
          $display("FAIL write: got idx=%0d data=%h tag=%b cyc=%0d, want idx=%0d data=%h tag=%b cyc=%0d",
                   fill_word_idx, fill_data, write_tag_array, cyc, w.idx, w.data, w.tag, w.cyc);
        end
      end
    end else if (write_tag_array) begin
      n_vec++;
      n_bad++;
      $display("FAIL stray_tag: tag=1 without data write, cyc=%0d, want tag=0", cyc);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) next_cycle();
  endtask

  task automatic wait_cyc(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check1(input string nm, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b (cyc=%0d)", nm, got, want, cyc);
    end
  endtask

  task automatic check_idle(input string nm);
    n_vec++;
    if (fsm_busy !== 1'b0 || mem_enable !== 1'b0 || mem_wr !== 1'b0 || memory_address !== 16'h0 ||
        write_data_array !== 1'b0 || fill_word_idx !== 3'd0 || write_tag_array !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: busy=%b en=%b wr=%b addr=%h wda=%b idx=%0d tag=%b, want all 0 (cyc=%0d)",
               nm, fsm_busy, mem_enable, mem_wr, memory_address, write_data_array,
               fill_word_idx, write_tag_array, cyc);
    end
  endtask

  task automatic push_fill(input logic [15:0] base, input int req0, input int wr0,
                           input int step, input int n, input bit tag_last);
    for (int i = 0; i < n; i++) begin
      exp_req.push_back('{req0 + i, base + 16'(2 * i)});
      exp_wr.push_back('{wr0 + step * i, 3'(i), mem_word(base + 16'(2 * i)),
                         tag_last && (i == n - 1)});
    end
  endtask

  task automatic wait_drain(input string nm);
    for (int k = 0; k < 64 && (exp_req.size() > 0 || exp_wr.size() > 0); k++) @(negedge clk);
    n_vec++;
    if (exp_req.size() > 0 || exp_wr.size() > 0 || pend.size() > 0) begin
      n_bad++;
      $display("FAIL %s: pending req=%0d wr=%0d mem=%0d, want 0/0/0",
               nm, exp_req.size(), exp_wr.size(), pend.size());
      exp_req.delete();
      exp_wr.delete();
      pend.delete();
    end
  endtask

  task automatic fill_zl(input logic [15:0] a, input logic [15:0] base);
    next_cycle();
    miss_address  = a;
    miss_detected = 1'b1;
    m = cyc;
    push_fill(base, m + 1, m + 1, 1, 8, 1'b1);
    next_cycle();
    miss_detected = 1'b0;
    wait_cyc(m + 1);
    check1("busy_rise", fsm_busy, 1'b1);
    wait_cyc(m + 8);
    check1("busy_last", fsm_busy, 1'b1);
    wait_cyc(m + 9);
    check1("busy_fall", fsm_busy, 1'b0);
    wait_drain("drain_zl");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: nothing moves for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle("idle");
    end

    fill_zl(16'h1236, 16'h1230);

    // Four-cycle memory latency at the top of the address space.
    zl = 1'b0; lat = 4; period = 0;
    next_cycle();
    miss_address = 16'hFFF2; miss_detected = 1'b1; m = cyc;
    push_fill(16'hFFF0, m + 1, m + 5, 1, 8, 1'b1);
    next_cycle();
    miss_detected = 1'b0;
    wait_cyc(m + 12);
    check1("lat4_busy_last", fsm_busy, 1'b1);
    wait_cyc(m + 13);
    check1("lat4_busy_fall", fsm_busy, 1'b0);
    wait_drain("drain_lat4");

    // Bursty valid, one response every third cycle.
    lat = 1; period = 3;
    next_cycle();
    miss_address = 16'h0A5C; miss_detected = 1'b1; m = cyc; gate_base = m + 2;
    push_fill(16'h0A50, m + 1, m + 2, 3, 8, 1'b1);
    next_cycle();
    miss_detected = 1'b0;
    wait_cyc(m + 23);
    check1("burst_busy_last", fsm_busy, 1'b1);
    wait_cyc(m + 24);
    check1("burst_busy_fall", fsm_busy, 1'b0);
    wait_drain("drain_burst");
    zl = 1'b1; lat = 0; period = 0;

    // Miss held through the fill while the address changes underneath.
    next_cycle();
    miss_address = 16'h1236; miss_detected = 1'b1; m = cyc;
    push_fill(16'h1230, m + 1, m + 1, 1, 8, 1'b1);
    push_fill(16'h4000, m + 10, m + 10, 1, 8, 1'b1);
    at_cycle(m + 3);
    miss_address = 16'h4000;
    wait_cyc(m + 9);
    check1("held_busy_fall", fsm_busy, 1'b0);
    at_cycle(m + 10);
    miss_detected = 1'b0;
    wait_cyc(m + 10);
    check1("held_busy_rise", fsm_busy, 1'b1);
    wait_drain("drain_held");
    wait_cyc(m + 18);
    check1("held_busy_end", fsm_busy, 1'b0);

    // Reset in the fourth fill cycle abandons the block.
    next_cycle();
    miss_address = 16'h2468; miss_detected = 1'b1; m = cyc;
    push_fill(16'h2460, m + 1, m + 1, 1, 4, 1'b0);
    next_cycle();
    miss_detected = 1'b0;
    at_cycle(m + 4);
    rst = 1'b1;
    at_cycle(m + 5);
    rst = 1'b0;
    wait_cyc(m + 5);
    check_idle("post_reset");
    wait_drain("drain_reset");
    fill_zl(16'h2468, 16'h2460);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation still running at cyc=%0d, want finished", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Initiator-side controller that drives the word-addressed, byte-addressable 16-bit memory port on a cache miss. It fetches one aligned block of BLOCK_WORDS words and streams each returned word into the cache data array. On the last word it pulses the tag-array write. It holds fsm_busy high so the pipeline stalls for the whole fill.

Parameters:
ADDR_WIDTH, 16, byte-address width; matches the memory addr port.
BLOCK_WORDS, 8, 16-bit words per cache block; power of two, at least 2.
OFFSET_BITS, 4, byte-offset bits per block; equals log2(BLOCK_WORDS)+1.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset; synchronous, active-high.
miss_detected  in  1  cache lookup missed this cycle; sampled only in IDLE.
miss_address  in  ADDR_WIDTH  byte address of the missing access.
memory_data  in  16  read data returned by memory.
memory_data_valid  in  1  memory_data is valid this cycle; tie to mem_enable for a zero-latency memory.
fsm_busy  out  1  fill in progress; stall the pipeline.
mem_enable  out  1  memory read request this cycle.
mem_wr  out  1  memory write strobe; constant 0, since the block only reads.
memory_address  out  ADDR_WIDTH  request byte address; bit 0 is always 0.
write_data_array  out  1  write fill_data into the data array at fill_word_idx.
fill_word_idx  out  log2(BLOCK_WORDS)  word index within the block for the current write.
fill_data  out  16  equals memory_data.
write_tag_array  out  1  single-cycle pulse: write the tag and set the valid bit for the block.

Behaviour:
- States: IDLE and FILL, held in a 1-bit state register.
- Registers:
  - base: the block address, {miss_address[ADDR_WIDTH-1:OFFSET_BITS], zeros}.
  - req_cnt: requests issued, range 0..BLOCK_WORDS.
  - rsp_cnt: responses received, range 0..BLOCK_WORDS-1.
- Reset: on any edge with rst=1, go to IDLE and clear base, req_cnt and rsp_cnt. This applies mid-fill too; the partial fill is abandoned and no tag write occurs.
- After reset, every output is 0: fsm_busy, mem_enable, mem_wr, memory_address, write_data_array, fill_word_idx, write_tag_array.
- IDLE, miss_detected=1: latch base, clear both counters, go to FILL on the next edge.
- IDLE, miss_detected=0: stay in IDLE. memory_data_valid is ignored in IDLE.
- Outputs in FILL:
  - fsm_busy = (state==FILL), decoded combinationally from state.
  - mem_enable = FILL and req_cnt < BLOCK_WORDS.
  - memory_address = base + 2*req_cnt while mem_enable=1; otherwise base.
  - req_cnt increments on each cycle that mem_enable=1.
- Responses:
  - write_data_array = FILL and memory_data_valid.
  - fill_word_idx = rsp_cnt.
  - rsp_cnt increments on each valid response.
  - Responses are in order. Request issue and response collection are independent, so memory latency may be 0..N cycles.
- Completion:
  - On the valid response with rsp_cnt == BLOCK_WORDS-1, write_tag_array=1 in that same cycle.
  - The next state is IDLE, so fsm_busy is low the following cycle.
  - Earliest new miss acceptance is the cycle after fsm_busy falls.
- miss_detected while in FILL is ignored, with no re-latch.
- Counter widths: req_cnt is log2(BLOCK_WORDS)+1 bits so it can saturate at BLOCK_WORDS. rsp_cnt wraps naturally but is cleared on entry to FILL.
- Address arithmetic is modulo 2^ADDR_WIDTH. The block is aligned, so there is no carry into the tag bits.
- Latency: with zero-latency memory, a miss in cycle 0 issues requests in cycles 1..BLOCK_WORDS and the tag write lands in cycle BLOCK_WORDS. fsm_busy is high for exactly BLOCK_WORDS cycles.

Decomposition:
- Shared package cache_pkg holds:
  - BLOCK_WORDS, OFFSET_BITS, WORD_IDX_W=log2(BLOCK_WORDS).
  - state typedef fill_state_t {IDLE, FILL}.
  - A function block_base(addr) that masks the offset bits.
- One natural sub-module: fill_counter, a parameterized clear/enable up-counter with a terminal-count flag. Instantiate it twice, once for requests and once for responses.

Test Plan:
- Reset, then idle with miss=0 -> all outputs 0 and no mem_enable for 20 cycles.
- Zero-latency memory, miss_address=0x1236 in cycle 0 ->
  - memory_address 0x1230, 0x1232, ..., 0x123E in cycles 1..8, with mem_enable=1 and mem_wr=0.
  - write_data_array with idx 0..7 in cycles 1..8.
  - write_tag_array only in cycle 8; fsm_busy high in cycles 1..8 and low in cycle 9.
- 4-cycle memory latency, miss 0xFFF2 ->
  - requests 0xFFF0..0xFFFE in cycles 1..8; responses in cycles 5..12 with idx 0..7.
  - tag pulse in cycle 12; fsm_busy low in cycle 13; no address wrap.
- Bursty valid (pattern 1,0,0,1,...) -> idx advances only on valid, data matches memory contents, exactly one tag pulse after the 8th valid.
- miss_detected held high throughout the fill with miss_address changed to 0x4000 mid-fill -> base stays 0x1230. The next fill, starting the cycle after busy falls, uses 0x4000.
- rst asserted in cycle 4 of a fill -> the next cycle is IDLE with all outputs 0 and no write_tag_array. A new miss then restarts from word 0.
